sum_msg_formatter: RTL
======================

Name: sum_msg_formatter

Overview:
- Sits between the sum-latch/adder stage and the UART byte transmitter.
- On a transmit request, snapshots operand A, operand B and their sum.
- Formats them as a fixed-width ASCII decimal message "AA+BB=SS\r\n".
- Streams the message byte-by-byte to the UART TX over a valid/ready handshake, so the serial terminal shows a human-readable result instead of raw binary.

Parameters:
- SEND_CRLF, 1, 1 = append 0x0D 0x0A (10-byte message); 0 = 8-byte message with no line ending.
- OP_CHAR, 8'h2B, ASCII operator character sent between operands ('+').

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  transmit request level (from uart_tx_en, already synchronised); internally edge-detected.
- operand_a  input  4  latched operand A, 0..15.
- operand_b  input  4  latched operand B, 0..15.
- sum_in  input  5  latched sum, 0..31.
- tx_data  output  8  ASCII byte offered to the UART TX.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART TX can accept a byte (i.e. not busy).
- busy  output  1  high while a message is in progress.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- One clock, clk; reset is synchronous and active-high, port name reset. All state updates on the clk rising edge.
- Reset values: tx_valid=0, tx_data=8'h00, busy=0, done=0, state=IDLE, byte index=0.
- Reset also sets start_q=1, so a start held high through reset does not trigger. start must go low and then high again.
- Start edge: rise = start & ~start_q, with start_q registered every cycle.
- States:
  - IDLE: on rise, capture operand_a, operand_b and sum_in into snapshot registers; index=0; go to SEND. Otherwise stay.
  - SEND: tx_valid=1, tx_data=byte[index], busy=1. On tx_valid & tx_ready:
    - if index==LAST, go to DONE;
    - else index+1, next byte presented the following cycle.
  - DONE: done=1 and tx_valid=0 for exactly one cycle; then go to IDLE with busy=0.
- Latency: a rise sampled in cycle N gives tx_valid=1 with byte 0 in cycle N+1.
- Throughput: at most one byte per cycle when tx_ready is held high.
- Byte order:
  - 0: tensA, 1: onesA, 2: OP_CHAR, 3: tensB, 4: onesB, 5: '=' (0x3D), 6: tensS, 7: onesS.
  - 8: 0x0D, 9: 0x0A when SEND_CRLF=1.
  - LAST = 9 when SEND_CRLF=1, else 7.
- Digit conversion of a value v (0..31):
  - tens = 3 if v>=30, 2 if v>=20, 1 if v>=10, else 0.
  - ones = v - 10*tens.
  - ASCII digit = 8'h30 + digit.
  - Leading zeros are always sent (fixed width).
- Handshake rules:
  - Once tx_valid rises, tx_data must stay stable until it is accepted.
  - tx_valid never drops without an accept, except on reset.
  - tx_ready low stalls indefinitely with no timeout.
- Edge cases:
  - A rise during SEND or DONE is ignored and not queued.
  - Changes on the operand or sum inputs mid-message do not affect the output, because only the snapshot is used.
  - sum_in is sent as received; no check against A+B is made here.
  - Reset mid-message: tx_valid=0 and state=IDLE the next cycle; the partial message is abandoned.

Decomposition:
- Shared package (sumlatch_pkg): state enum {IDLE, SEND, DONE}, ASCII constants (ASCII_0, ASCII_EQ, ASCII_CR, ASCII_LF), MSG_LEN_CRLF=10, MSG_LEN_NOCRLF=8.
- One sub-module, bin2dec2: 5-bit input to two 4-bit decimal digits, purely combinational.
  - Instantiated three times, for A, B and sum, on the snapshot registers.

Test Plan:
- A=7, B=9, sum=16, start rise, tx_ready=1 -> bytes 30 37 2B 30 39 3D 31 36 0D 0A on consecutive cycles starting N+1; done pulses once; busy falls with done.
- A=15, B=15, sum=30, with tx_ready toggling randomly -> same "15+15=30\r\n" sequence; tx_data stable whenever tx_valid=1 and tx_ready=0; no bytes lost or duplicated.
- A=0, B=0, sum=0, SEND_CRLF=0 -> exactly 8 bytes "00+00=00"; done follows acceptance of byte 7.
- Second start rise and operand change (A 3->12) during byte 2 -> ignored; message still shows the original snapshot A=03; no second message sent.
- Reset asserted while byte 4 is pending -> tx_valid=0 and busy=0 the next cycle. A start held high through reset produces nothing until start goes low then high; after that, the message restarts from byte 0.
- start held high for 50 cycles -> exactly one message sent.

Source files
------------

// File: rtl/sumlatch_pkg.sv
// sumlatch_pkg: shared states and ASCII constants for the sum message formatter.
package sumlatch_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int MSG_LEN_CRLF   = 10;
  localparam int MSG_LEN_NOCRLF = 8;
endpackage

// File: rtl/bin2dec2.sv
// bin2dec2: splits a 0..31 value into tens and ones decimal digits.
module bin2dec2 (
  input  logic [4:0] v,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [4:0] base;
  always_comb begin
    base = v >= 5'd30 ? 5'd30 : v >= 5'd20 ? 5'd20 : v >= 5'd10 ? 5'd10 : 5'd0;
    tens = v >= 5'd30 ? 4'd3 : v >= 5'd20 ? 4'd2 : v >= 5'd10 ? 4'd1 : 4'd0;
    ones = 4'(v - base);
  end
endmodule

// File: rtl/sum_msg_formatter.sv
// sum_msg_formatter: snapshots A, B and sum on a start edge and streams "AA+BB=SS\r\n" over valid/ready.
module sum_msg_formatter
  import sumlatch_pkg::*;
#(
  parameter bit          SEND_CRLF = 1'b1,
  parameter logic [7:0]  OP_CHAR   = 8'h2B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] operand_a,
  input  logic [3:0] operand_b,
  input  logic [4:0] sum_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);
  localparam logic [3:0] LAST = 4'(SEND_CRLF ? MSG_LEN_CRLF - 1 : MSG_LEN_NOCRLF - 1);
  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [4:0] s_q, s_d;
  logic       start_q, rise;
  logic [3:0] a_t, a_o, b_t, b_o, s_t, s_o;
  logic [7:0] msg [10];
  bin2dec2 u_dec_a (.v({1'b0, a_q}), .tens(a_t), .ones(a_o));
  bin2dec2 u_dec_b (.v({1'b0, b_q}), .tens(b_t), .ones(b_o));
  bin2dec2 u_dec_s (.v(s_q),         .tens(s_t), .ones(s_o));
  assign rise = start & ~start_q;
  always_comb begin
    msg[0] = ASCII_0 + 8'(a_t);
    msg[1] = ASCII_0 + 8'(a_o);
    msg[2] = OP_CHAR;
    msg[3] = ASCII_0 + 8'(b_t);
    msg[4] = ASCII_0 + 8'(b_o);
    msg[5] = ASCII_EQ;
    msg[6] = ASCII_0 + 8'(s_t);
    msg[7] = ASCII_0 + 8'(s_o);
    msg[8] = ASCII_CR;
    msg[9] = ASCII_LF;
  end
  // Outputs decode straight from state, so tx_data cannot move until the index advances on accept.
  always_comb begin
    tx_valid = state_q == SEND;
    tx_data  = state_q == SEND ? msg[idx_q] : 8'h00;
    busy     = state_q != IDLE;
    done     = state_q == DONE;
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    case (state_q)
      IDLE: if (rise) begin
        a_d     = operand_a;
        b_d     = operand_b;
        s_d     = sum_in;
        idx_d   = 4'd0;
        state_d = SEND;
      end
      SEND: if (tx_ready) begin
        state_d = idx_q == LAST ? DONE : SEND;
        idx_d   = idx_q == LAST ? idx_q : idx_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      s_q     <= 5'd0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      start_q <= start;
    end
  end
endmodule
